// File: rtl/psum_accum_ctrl_if.sv
// Request/response bundle for the partial-sum accumulator bank.
// No state: wiring only, so it adds no latency.
// in_valid/in_ready handshake on the request side; out_valid is a one-cycle pulse with no backpressure.
interface psum_accum_ctrl_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_mode;
  logic [addr_bw-1:0]     in_addr;
  logic [psum_bw*col-1:0] in_data;
  logic                   clear_start;
  logic                   busy;
  logic                   out_valid;
  logic [addr_bw-1:0]     out_addr;
  logic [psum_bw*col-1:0] out_data;
  logic                   sat_flag;

  modport master (
    output in_valid, in_mode, in_addr, in_data, clear_start,
    input  in_ready, busy, out_valid, out_addr, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_mode, in_addr, in_data, clear_start,
    output in_ready, busy, out_valid, out_addr, out_data, sat_flag
  );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Pipelined read-modify-write partial-sum bank: WRITE, saturating ACCUM, ReLU READ, hardware clear sweep.
// Latency: a request accepted at edge k commits its write, or presents its READ output, at edge k+2.
// in_ready drops only outside IDLE or while clear_start is high; the pipeline itself never stalls.
module psum_accum_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 2048,
  parameter int addr_bw = 11
) (
  input logic              clk,
  input logic              reset,
  psum_accum_ctrl_if.slave bus
);
  localparam int W = psum_bw * col;
  localparam logic [1:0] MODE_WRITE = 2'd0;
  localparam logic [1:0] MODE_ACCUM = 2'd1;
  localparam logic [1:0] MODE_READ  = 2'd2;
  localparam logic [addr_bw-1:0] LAST_ADDR = addr_bw'(depth - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, CLEAR = 2'd2} state_t;

  state_t             state;
  logic               idle;
  logic [addr_bw-1:0] clr_cnt;

  logic               s1_vld;
  logic [1:0]         s1_mode;
  logic [addr_bw-1:0] s1_addr;
  logic [W-1:0]       s1_data;

  logic               s2_vld;
  logic [1:0]         s2_mode;
  logic [addr_bw-1:0] s2_addr;
  logic [W-1:0]       s2_data;
  logic [W-1:0]       s2_q;

  logic               fwd_vld;
  logic [addr_bw-1:0] fwd_addr;
  logic [W-1:0]       fwd_data;

  logic               out_vld_r;
  logic [addr_bw-1:0] out_addr_r;
  logic [W-1:0]       out_data_r;
  logic               sat_r;

  logic [W-1:0]       bank [depth];

  logic               accept;
  logic               enter_clear;
  logic [W-1:0]       old_data;
  logic [W-1:0]       acc_data;
  logic [W-1:0]       relu_data;
  logic [col-1:0]     lane_sat;
  logic               pipe_we;
  logic [W-1:0]       wr_data;
  logic               mem_we;
  logic [addr_bw-1:0] mem_addr;
  logic [W-1:0]       mem_wdata;

  // clear_start is combinational into in_ready so a same-cycle request loses to the clear.
  assign bus.in_ready  = idle & ~bus.clear_start;
  assign bus.busy      = ~idle;
  assign bus.out_valid = out_vld_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_data  = out_data_r;
  assign bus.sat_flag  = sat_r;

  assign accept      = bus.in_valid & bus.in_ready;
  assign enter_clear = (state == DRAIN) & ~s1_vld & ~s2_vld;

  // The write committed at the previous edge is not yet visible in s2_q (read-first bank), so bypass it.
  assign old_data = (fwd_vld && fwd_addr == s2_addr) ? fwd_data : s2_q;

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] a;
    logic [psum_bw-1:0] b;
    logic [psum_bw:0]   sum;
    logic               ovf;
    assign a   = old_data[psum_bw*i +: psum_bw];
    assign b   = s2_data[psum_bw*i +: psum_bw];
    assign sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    // Overflow when the extra sign bit disagrees; its value tells which rail to clamp to.
    assign ovf = sum[psum_bw] ^ sum[psum_bw-1];
    assign acc_data[psum_bw*i +: psum_bw]  = ovf ? {sum[psum_bw], {(psum_bw-1){~sum[psum_bw]}}}
                                                 : sum[psum_bw-1:0];
    assign relu_data[psum_bw*i +: psum_bw] = a[psum_bw-1] ? '0 : a;
    assign lane_sat[i] = ovf;
  end

  assign pipe_we = s2_vld & ((s2_mode == MODE_WRITE) | (s2_mode == MODE_ACCUM));
  assign wr_data = (s2_mode == MODE_WRITE) ? s2_data : acc_data;

  // The clear sweep owns the write port; the pipeline is empty whenever state is CLEAR.
  assign mem_we    = pipe_we | (state == CLEAR);
  assign mem_addr  = (state == CLEAR) ? clr_cnt : s2_addr;
  assign mem_wdata = (state == CLEAR) ? '0 : wr_data;

  // Control FSM: IDLE -> DRAIN (wait for pipeline empty) -> CLEAR (depth-cycle zero sweep) -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idle    <= 1'b1;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear_start) begin
            state <= DRAIN;
            idle  <= 1'b0;
          end
        end
        DRAIN: begin
          if (enter_clear) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + addr_bw'(1);
          if (clr_cnt == LAST_ADDR) begin
            state <= IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  // Request pipeline, forward register, READ output and sticky saturation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld     <= 1'b0;
      s1_mode    <= '0;
      s1_addr    <= '0;
      s1_data    <= '0;
      s2_vld     <= 1'b0;
      s2_mode    <= '0;
      s2_addr    <= '0;
      s2_data    <= '0;
      fwd_vld    <= 1'b0;
      fwd_addr   <= '0;
      fwd_data   <= '0;
      out_vld_r  <= 1'b0;
      out_addr_r <= '0;
      out_data_r <= '0;
      sat_r      <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_mode <= bus.in_mode;
        s1_addr <= bus.in_addr;
        s1_data <= bus.in_data;
      end
      s2_vld  <= s1_vld;
      s2_mode <= s1_mode;
      s2_addr <= s1_addr;
      s2_data <= s1_data;

      fwd_vld  <= pipe_we & ~enter_clear;
      fwd_addr <= s2_addr;
      fwd_data <= wr_data;

      out_vld_r <= s2_vld & (s2_mode == MODE_READ);
      if (s2_vld && s2_mode == MODE_READ) begin
        out_addr_r <= s2_addr;
        out_data_r <= relu_data;
      end

      if (enter_clear)
        sat_r <= 1'b0;
      else if (pipe_we && s2_mode == MODE_ACCUM && |lane_sat)
        sat_r <= 1'b1;
    end
  end

  // Bank storage: read of the S1 address lands in s2_q; read-first against the same-edge write.
  always_ff @(posedge clk) begin
    if (mem_we)
      bank[mem_addr] <= mem_wdata;
    s2_q <= bank[s1_addr];
  end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Self-checking bench for psum_accum_ctrl with a lane-array reference model.
// Outputs sampled 1 time unit after the rising edge; READ pulses captured on the falling edge.
// Requests are driven only while in_ready is observed; stalls are counted where none are expected.
module tb_psum_accum_ctrl;
  localparam int COL = 8;
  localparam int BW = 16;
  localparam int DEPTH = 2048;
  localparam int AW = 11;
  localparam int W = COL * BW;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  typedef struct {
    int           cyc;
    int           addr;
    logic [W-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  rd_t  exp_q[$];
  rd_t  got_q[$];
  int   model [DEPTH][COL];
  bit   model_sat;
  bit   dummy;

  psum_accum_ctrl_if #(.col(COL), .psum_bw(BW), .addr_bw(AW)) bus ();

  psum_accum_ctrl #(.col(COL), .psum_bw(BW), .depth(DEPTH), .addr_bw(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge E, cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every READ pulse with the edge number it followed.
  always @(negedge clk) if (bus.out_valid === 1'b1) got_q.push_back('{cyc, int'(bus.out_addr), bus.out_data});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic int lane_of(input logic [W-1:0] d, input int i);
    logic signed [BW-1:0] v;
    v = d[BW*i +: BW];
    return int'(v);
  endfunction

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[BW*i +: BW] = BW'(v);
    return r;
  endfunction

  function automatic int clamp(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic logic [W-1:0] relu_of(input int addr);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[BW*i +: BW] = (model[addr][i] < 0) ? '0 : BW'(model[addr][i]);
    return r;
  endfunction

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < COL; i++) model[a][i] = 0;
    model_sat = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one request for one cycle; apply it to the model in order if it was accepted.
  task automatic issue(input logic [1:0] mode, input int addr, input logic [W-1:0] data, output bit acc);
    int e;
    int s;
    bus.in_valid = 1'b1; bus.in_mode = mode; bus.in_addr = AW'(addr); bus.in_data = data;
    acc = bus.in_ready;
    e = cyc + 1;
    @(posedge clk);
    if (acc) begin
      if (mode == 2'd0) begin
        for (int i = 0; i < COL; i++) model[addr][i] = lane_of(data, i);
      end else if (mode == 2'd1) begin
        for (int i = 0; i < COL; i++) begin
          s = model[addr][i] + lane_of(data, i);
          if (s > MAXV || s < MINV) model_sat = 1'b1;
          model[addr][i] = clamp(s);
        end
      end else if (mode == 2'd2) begin
        exp_q.push_back('{e + 2, addr, relu_of(addr)});
      end
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Single-cycle clear_start pulse; returns how many post-edge samples showed busy.
  task automatic pulse_clear(output int n, output logic rdy_seen);
    bus.clear_start = 1'b1;
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    rdy_seen = bus.in_ready;
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_addr = '0; bus.in_data = '0; bus.clear_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr: got %0d expected 0", bus.out_addr); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag: got %b expected 0", bus.sat_flag); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    reset = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_clear_busy();
    int n;
    logic rdy;
    pulse_clear(n, rdy);
    model_zero();
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready_low: got %b expected 0", rdy); end
    n_checks++; if (n != DEPTH + 1) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected %0d", n, DEPTH + 1); end
    got_q.delete(); exp_q.delete();
    issue(2'd2, 5, '0, dummy);
    idle_cycles(1);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL read_early_valid: got %b expected 0 at k+1", bus.out_valid); end
    idle_cycles(1);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL read_latency_valid: got %b expected 1 at k+2", bus.out_valid); end
    n_checks++; if (bus.out_addr !== AW'(5)) begin n_fail++; $display("FAIL read_addr5: got %0d expected 5", bus.out_addr); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL read_cleared_data: got %h expected 0", bus.out_data); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL clear_sat_flag: got %b expected 0", bus.sat_flag); end
    idle_cycles(2);
  endtask

  task automatic test_forward();
    bit a;
    int stalls = 0;
    got_q.delete(); exp_q.delete();
    issue(2'd0, 3, fill(100), a); if (!a) stalls++;
    issue(2'd1, 3, fill(23), a);  if (!a) stalls++;
    issue(2'd2, 3, '0, a);        if (!a) stalls++;
    idle_cycles(4);
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL fwd_stalls: got %0d expected 0", stalls); end
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL fwd_read_count: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== fill(123)) begin n_fail++; $display("FAIL fwd_sum: got %h expected %h", got_q[0].data, fill(123)); end
      n_checks++; if (got_q[0].cyc != exp_q[0].cyc) begin n_fail++; $display("FAIL fwd_latency: got edge %0d expected %0d", got_q[0].cyc, exp_q[0].cyc); end
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int stalls = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin issue(2'd1, 3, fill(1), a); if (!a) stalls++; end
    issue(2'd2, 3, '0, a); if (!a) stalls++;
    idle_cycles(4);
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d expected 0", stalls); end
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL b2b_read_count: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== fill(126)) begin n_fail++; $display("FAIL b2b_sum: got %h expected %h", got_q[0].data, fill(126)); end
    end
  endtask

  task automatic test_saturation();
    got_q.delete(); exp_q.delete();
    issue(2'd0, 7, fill(32000), dummy);
    issue(2'd1, 7, fill(1000), dummy);
    issue(2'd2, 7, '0, dummy);
    idle_cycles(4);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL satpos_read_count: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== fill(MAXV)) begin n_fail++; $display("FAIL satpos_value: got %h expected %h", got_q[0].data, fill(MAXV)); end
    end
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL satpos_flag: got %b expected 1", bus.sat_flag); end
    // -30000 twice clamps to -32768; two +32767 steps then land on 32766 (5534 if unclamped).
    got_q.delete(); exp_q.delete();
    issue(2'd1, 8, fill(-30000), dummy);
    issue(2'd1, 8, fill(-30000), dummy);
    issue(2'd1, 8, fill(32767), dummy);
    issue(2'd1, 8, fill(32767), dummy);
    issue(2'd2, 8, '0, dummy);
    idle_cycles(4);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL satneg_read_count: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== fill(32766)) begin n_fail++; $display("FAIL satneg_value: got %h expected %h", got_q[0].data, fill(32766)); end
    end
  endtask

  task automatic test_relu();
    logic [W-1:0] d;
    logic [W-1:0] want;
    for (int i = 0; i < COL; i++) begin
      d[BW*i +: BW]    = (i % 2 == 0) ? BW'(-5) : BW'(7);
      want[BW*i +: BW] = (i % 2 == 0) ? BW'(0) : BW'(7);
    end
    got_q.delete(); exp_q.delete();
    issue(2'd0, 9, d, dummy);
    issue(2'd2, 9, '0, dummy);
    issue(2'd2, 9, '0, dummy);
    idle_cycles(4);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL relu_read_count: got %0d expected 2", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== want) begin n_fail++; $display("FAIL relu_first: got %h expected %h", got_q[0].data, want); end
      n_checks++; if (got_q[1].data !== want) begin n_fail++; $display("FAIL relu_second: got %h expected %h", got_q[1].data, want); end
    end
  endtask

  task automatic test_random();
    bit a;
    int stalls = 0;
    logic [W-1:0] d;
    logic [1:0] m;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < COL; i++) d[BW*i +: BW] = BW'(int'($urandom_range(0, 40000)) - 20000);
      m = 2'($urandom_range(0, 3));
      issue(m, int'($urandom_range(0, 15)), d, a);
      if (!a) stalls++;
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end
    idle_cycles(4);
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL rand_stalls: got %0d expected 0", stalls); end
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_read_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].cyc != exp_q[i].cyc || got_q[i].addr != exp_q[i].addr || got_q[i].data !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL rand_read[%0d]: got edge %0d addr %0d data %h expected edge %0d addr %0d data %h",
                 i, got_q[i].cyc, got_q[i].addr, got_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
      end
    end
    n_checks++; if (bus.sat_flag !== model_sat) begin n_fail++; $display("FAIL rand_sat_flag: got %b expected %b", bus.sat_flag, model_sat); end
  endtask

  task automatic test_clear_collision();
    int n;
    bit a;
    logic rdy;
    got_q.delete(); exp_q.delete();
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL coll_sat_before: got %b expected 1", bus.sat_flag); end
    issue(2'd1, 2, fill(5), dummy);
    bus.in_valid = 1'b1; bus.in_mode = 2'd1; bus.in_addr = AW'(2); bus.in_data = fill(9);
    bus.clear_start = 1'b1;
    #1;
    a = bus.in_ready;
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL coll_in_ready: got %b expected 0", a); end
    bus.clear_start = 1'b0;
    bus.in_valid = 1'b0;
    pulse_clear(n, rdy);
    model_zero();
    // Pulse arrived with one ACCUM still in S1, so DRAIN lasts two cycles.
    n_checks++; if (n != DEPTH + 2) begin n_fail++; $display("FAIL coll_busy_cycles: got %0d expected %0d", n, DEPTH + 2); end
    issue(2'd2, 2, '0, dummy);
    idle_cycles(3);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL coll_read_count: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== '0) begin n_fail++; $display("FAIL coll_read_zero: got %h expected 0", got_q[0].data); end
    end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL coll_sat_after: got %b expected 0", bus.sat_flag); end
  endtask

  task automatic test_reset_mid();
    bus.clear_start = 1'b1;
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    idle_cycles(100);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy: got %b expected 1", bus.busy); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midclr_reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midclr_reset_valid: got %b expected 0", bus.out_valid); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(1);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midclr_after_busy: got %b expected 0", bus.busy); end

    got_q.delete(); exp_q.delete();
    model_sat = 1'b0;
    issue(2'd0, 4, fill(50), dummy);
    issue(2'd0, 5, fill(MAXV), dummy);
    issue(2'd1, 5, fill(MAXV), dummy);
    issue(2'd2, 4, '0, dummy);
    idle_cycles(3);
    n_checks++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL midpipe_sat_before: got %b expected 1", bus.sat_flag); end
    n_checks++; if (bus.out_data !== fill(50)) begin n_fail++; $display("FAIL midpipe_data_before: got %h expected %h", bus.out_data, fill(50)); end

    got_q.delete(); exp_q.delete();
    issue(2'd1, 4, fill(10), dummy);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.out_addr !== '0) begin n_fail++; $display("FAIL midpipe_reset_addr: got %0d expected 0", bus.out_addr); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL midpipe_reset_data: got %h expected 0", bus.out_data); end
    n_checks++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL midpipe_reset_sat: got %b expected 0", bus.sat_flag); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    // The in-flight ACCUM is dropped: address 4 keeps its pre-reset value.
    for (int i = 0; i < COL; i++) model[4][i] = 50;
    idle_cycles(2);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midpipe_after_busy: got %b expected 0", bus.busy); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midpipe_spurious_valid: got %0d pulses expected 0", got_q.size()); end
    issue(2'd2, 4, '0, dummy);
    idle_cycles(3);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL midpipe_read_count: got %0d expected 1", got_q.size()); end
    else begin
      n_checks++; if (got_q[0].data !== relu_of(4)) begin n_fail++; $display("FAIL midpipe_no_partial_write: got %h expected %h", got_q[0].data, relu_of(4)); end
    end
  endtask

  initial begin
    test_reset();
    test_clear_busy();
    test_forward();
    test_back_to_back();
    test_saturation();
    test_relu();
    test_random();
    test_clear_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
